// File: rtl/neuron_accum_ctrl.sv
// neuron_accum_ctrl: time-shares an external adder to accumulate a bias plus N_INPUTS streamed terms
module neuron_accum_ctrl #(
  parameter int WIDTH    = 8,
  parameter int N_INPUTS = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] bias,
  input  logic             in_valid,
  input  logic [WIDTH-1:0] in_data,
  output logic             in_ready,
  output logic [WIDTH-1:0] add_a,
  output logic [WIDTH-1:0] add_b,
  input  logic [WIDTH-1:0] add_sum,
  output logic             busy,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result
);
  typedef enum logic [1:0] {IDLE, ACCUM, DONE} state_t;
  state_t state, state_n;
  logic [WIDTH-1:0] acc;
  logic [7:0] cnt;
  logic load, accept;
  assign load   = (state == IDLE) && start;
  assign accept = (state == ACCUM) && in_valid;
  always_comb begin
    state_n = state;
    if (load) state_n = ACCUM;
    if (accept && cnt == 8'(N_INPUTS - 1)) state_n = DONE;
    if (state == DONE && out_ready) state_n = IDLE;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      acc   <= '0;
      cnt   <= '0;
    end else begin
      state <= state_n;
      if (load) begin
        acc <= bias;
        cnt <= '0;
      end else if (accept) begin
        acc <= add_sum;
        cnt <= cnt + 8'd1;
      end
    end
  end
  assign in_ready  = (state == ACCUM);
  assign out_valid = (state == DONE);
  assign busy      = (state != IDLE);
  assign add_a     = (state == ACCUM) ? acc : '0;
  assign add_b     = (state == ACCUM) ? in_data : '0;
  assign result    = acc;
endmodule

// File: tb/tb_neuron_accum_ctrl.sv
// tb_neuron_accum_ctrl: directed and randomized evaluations against a sum-of-terms reference model
module tb_neuron_accum_ctrl;
  logic clk = 0;
  logic rst, start, in_valid, out_ready;
  logic [7:0] bias, in_data;
  logic in_ready, busy, out_valid;
  logic [7:0] add_a, add_b, add_sum, result;
  logic u_start, u_in_valid, u_out_ready;
  logic [7:0] u_bias, u_in_data;
  logic u_in_ready, u_busy, u_out_valid;
  logic [7:0] u_a, u_b, u_sum, u_result;
  int compared = 0, mismatched = 0;

  always #5 clk = ~clk;
  assign add_sum = add_a + add_b;
  assign u_sum   = u_a + u_b;

  neuron_accum_ctrl #(.WIDTH(8), .N_INPUTS(4)) dut (
    .clk(clk), .rst(rst), .start(start), .bias(bias), .in_valid(in_valid), .in_data(in_data),
    .in_ready(in_ready), .add_a(add_a), .add_b(add_b), .add_sum(add_sum), .busy(busy),
    .out_valid(out_valid), .out_ready(out_ready), .result(result));

  neuron_accum_ctrl #(.WIDTH(8), .N_INPUTS(1)) dut1 (
    .clk(clk), .rst(rst), .start(u_start), .bias(u_bias), .in_valid(u_in_valid), .in_data(u_in_data),
    .in_ready(u_in_ready), .add_a(u_a), .add_b(u_b), .add_sum(u_sum), .busy(u_busy),
    .out_valid(u_out_valid), .out_ready(u_out_ready), .result(u_result));

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk); #1;
  endtask

  task automatic chk_idle(input string tag, input bit with_result);
    chk({tag, "_busy"}, busy, 0);
    chk({tag, "_in_ready"}, in_ready, 0);
    chk({tag, "_out_valid"}, out_valid, 0);
    chk({tag, "_add_a"}, add_a, 0);
    chk({tag, "_add_b"}, add_b, 0);
    if (with_result) chk({tag, "_result"}, result, 0);
  endtask

  // One evaluation: expected result is bias plus every term, modulo 2^8.
  // Starts from an IDLE cycle whose negedge has passed; ends the same way after `tail` extra IDLE cycles.
  task automatic run4(input logic [7:0] b, input logic [7:0] t [4], input bit alt,
                      input int pct, input int hold, input int tail);
    logic [7:0] part, exp;
    int i, cyc;
    bit v;
    exp = b;
    foreach (t[k]) exp += t[k];
    start = 1; bias = b; in_valid = 1'($urandom); in_data = 8'($urandom);
    step();
    start = 0; bias = 8'($urandom);
    part = b; i = 0; cyc = 0;
    while (i < 4 && cyc < 200) begin
      v = alt ? (cyc % 2 == 0) : ($urandom_range(99) >= pct);
      in_valid = v; in_data = v ? t[i] : 8'($urandom); start = 1'($urandom);
      @(negedge clk);
      chk("acc_in_ready", in_ready, 1);
      chk("acc_out_valid", out_valid, 0);
      chk("acc_busy", busy, 1);
      chk("acc_add_a", add_a, part);
      chk("acc_add_b", add_b, in_data);
      step();
      if (v) begin part += t[i]; i++; end
      cyc++;
    end
    chk("accept_count", i, 4);
    if (!alt && pct == 0) chk("latency", cyc, 4);
    start = 0; in_valid = 1'($urandom); in_data = 8'($urandom); out_ready = 0;
    for (int h = 0; h <= hold; h++) begin
      out_ready = (h == hold); start = (h == hold);
      @(negedge clk);
      chk("done_out_valid", out_valid, 1);
      chk("done_result", result, exp);
      chk("done_in_ready", in_ready, 0);
      chk("done_busy", busy, 1);
      chk("done_add_a", add_a, 0);
      chk("done_add_b", add_b, 0);
      step();
    end
    start = 0; out_ready = 0; in_valid = 1; in_data = 8'($urandom);
    for (int k = 0; k <= tail; k++) begin
      @(negedge clk);
      chk_idle("post", 0);
      if (k < tail) step();
    end
  endtask

  initial begin
    rst = 1; start = 0; bias = 0; in_valid = 0; in_data = 0; out_ready = 0;
    u_start = 0; u_bias = 0; u_in_valid = 0; u_in_data = 0; u_out_ready = 0;
    repeat (3) step();
    @(negedge clk);
    chk_idle("reset", 1);
    chk("reset_u_busy", u_busy, 0);
    chk("reset_u_result", u_result, 0);
    step();
    rst = 0;
    @(negedge clk);
    chk_idle("idle", 1);

    run4(8'h05, '{8'h01, 8'h02, 8'h03, 8'h04}, 0, 0, 0, 1);
    run4(8'h05, '{8'h01, 8'h02, 8'h03, 8'h04}, 1, 0, 3, 1);

    start = 1; bias = 8'h99;
    step();
    start = 0; in_valid = 1; in_data = 8'h22;
    step(); step();
    rst = 1;
    step();
    rst = 0; in_valid = 0;
    @(negedge clk);
    chk_idle("midrst", 1);
    run4(8'h00, '{8'h10, 8'h10, 8'h10, 8'h10}, 0, 0, 0, 0);
    run4(8'hF0, '{8'h20, 8'h7F, 8'h01, 8'hC3}, 0, 0, 0, 0);

    for (int r = 0; r < 20; r++)
      run4(8'($urandom), '{8'($urandom), 8'($urandom), 8'($urandom), 8'($urandom)},
           0, $urandom_range(60), $urandom_range(3), $urandom_range(2));

    u_start = 1; u_bias = 8'h33;
    step();
    u_start = 0; u_in_valid = 1; u_in_data = 8'h4B;
    @(negedge clk);
    chk("n1_in_ready", u_in_ready, 1);
    chk("n1_add_a", u_a, 8'h33);
    chk("n1_add_b", u_b, 8'h4B);
    step();
    u_in_valid = 0; u_out_ready = 1;
    @(negedge clk);
    chk("n1_out_valid", u_out_valid, 1);
    chk("n1_result", u_result, 8'h7E);
    chk("n1_in_ready_done", u_in_ready, 0);
    step();
    u_out_ready = 0;
    @(negedge clk);
    chk("n1_idle_out_valid", u_out_valid, 0);
    chk("n1_idle_busy", u_busy, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end
endmodule
